fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Framebuffer access arbiter and double-buffer swap controller. It sits between one single-port synchronous framebuffer RAM and three requesters:
- the display read path, which has fixed top priority and feeds the RGB generator;
- the GPU core write port;
- the GPU core read port.

The RAM holds two 64x64 8-bit banks. The display always reads the front bank, and the core always accesses the back bank. A core swap request is deferred to the next end-of-frame pulse.

## Interface
- ADDR_W, 12, pixel address width per bank (64x64).
- DATA_W, 8, pixel width.

- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low; the block is held in reset on every edge where reset==0.
- disp_req  in  1  display read request, one per cycle, never stalled.
- disp_addr  in  ADDR_W  display pixel address.
- disp_rvalid  out  1  disp_rdata valid.
- disp_rdata  out  DATA_W  display read data.
- wr_valid / wr_ready  in / out  1  core write handshake; a transfer occurs when both are 1.
- wr_addr, wr_data  in  ADDR_W, DATA_W  core write address and data.
- rd_valid / rd_ready  in / out  1  core read handshake.
- rd_addr  in  ADDR_W  core read address.
- rd_rvalid  out  1  rd_rdata valid.
- rd_rdata  out  DATA_W  core read data.
- frame_start  in  1  one-cycle pulse at end of visible frame (x=640, y=480).
- swap_req  in  1  one-cycle pulse requesting a front/back exchange.
- swap_ack  out  1  one-cycle pulse, swap done.
- front_bank  out  1  current display bank.
- ram_en, ram_we  out  1  RAM enable and write enable.
- ram_addr  out  ADDR_W+1  RAM address = {bank, addr}.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the ram_en read edge.

## Operation
**Arbitration**, evaluated every cycle:
- Priority is disp > core (wr/rd).
- wr_ready = ~disp_req & ~swap_pending & (grant to wr).
- rd_ready is symmetric to wr_ready.
- wr_ready and rd_ready are combinational from the current inputs and state.
- When both wr_valid and rd_valid are asserted, a 1-bit last_core register decides: the port not served last wins. last_core updates only on a completed core transfer.
- A lone valid core port wins immediately.

**Grant encoding:** NONE, DISP, WR, RD. The grant is registered into the RAM outputs at the next edge.

**Bank selection:**
- The display uses front_bank.
- Core accesses use ~front_bank.
- The bank is sampled on the handshake/request cycle.

**Read return tags:** a 2-deep shift of {is_disp, is_rd} tags routes ram_rdata to disp_* or rd_*.

**Swap FSM**, states RUN and PEND (reset: RUN):
- In RUN, swap_req moves the FSM to PEND. If frame_start is also high in that cycle, it goes directly to SWAP.
- In PEND, frame_start moves the FSM to SWAP.
- SWAP lasts 1 cycle: it toggles front_bank, pulses swap_ack, and returns to RUN.
- swap_pending = (state != RUN). Core ready is held at 0 while swap_pending, so the back buffer is frozen during the wait.
- swap_req in PEND or SWAP is ignored.

**Reset values:**
- All outputs are 0: ram_*, disp_rvalid, rd_rvalid, swap_ack, front_bank, wr_ready, rd_ready.
- Internal state: FSM in RUN, last_core = RD (so a write wins the first contest), tag pipe cleared.

**Reset mid-operation:** in-flight reads are discarded, and no rvalid is produced after reset deasserts.

## Timing
- Cycle t: request or handshake.
- Edge t+1: ram_en, ram_we, ram_addr and ram_wdata are driven (registered).
- Edge t+2: ram_rdata is returned and registered into disp_rdata / rd_rdata, with the matching rvalid high for 1 cycle.
- Read latency is therefore 2 cycles. rgb_gen must present disp_addr 2 cycles ahead of the pixel.
- Writes complete at edge t+1 and produce no response.
- Throughput is 1 RAM access per cycle. Core bandwidth exists only in cycles without disp_req (blanking and the right-hand border).
- swap_ack and the front_bank toggle appear on the edge after the frame_start edge that completes the swap.
- A display read issued in the frame_start cycle uses the old front_bank.

## Structure
- The shared package fb_pkg holds ADDR_W, DATA_W, the grant encoding (GNT_NONE/DISP/WR/RD) and the swap state encoding (SWAP_RUN/PEND/DO).
- The sub-module fb_swap_ctrl contains the swap FSM. Its interface is swap_req, frame_start, swap_ack, front_bank and swap_pending.
- The arbitration, RAM register stage and tag pipe stay in fb_arbiter.

## Test plan
- disp_req=1 with disp_addr=0x123 and wr_valid=1 held → wr_ready=0 throughout. ram_addr={0,0x123}, and disp_rvalid rises 2 cycles later with the RAM content.
- disp_req=0 with wr_valid and rd_valid both held → grants alternate WR, RD, WR, with WR first after reset. Writes hit ram_addr[12]=1, and rd_rvalid follows each RD by 2 cycles.
- Write 0xAB to 0x040 in the back bank, pulse swap_req, then pulse frame_start → the FSM is in PEND with ready=0 until frame_start. swap_ack and front_bank=1 appear 1 cycle after frame_start. A display read of 0x040 then returns 0xAB.
- swap_req and frame_start in the same cycle → front_bank toggles on the next edge with no PEND cycles. A second swap_req during SWAP is ignored.
- Reset asserted (reset=0) one cycle after a rd handshake → no rd_rvalid, all outputs 0, front_bank=0, and the FSM returns to RUN.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared widths, grant encoding and swap-state encoding for the framebuffer arbiter.
package fb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } grant_t;

    typedef enum logic [1:0] {
        SWAP_RUN  = 2'd0,
        SWAP_PEND = 2'd1,
        SWAP_DO   = 2'd2
    } swap_state_t;

    function automatic logic [ADDR_W:0] bank_addr(input logic bank, input logic [ADDR_W-1:0] addr);
        return {bank, addr};
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of requester, swap-control and RAM-side signals around the framebuffer arbiter.
interface fb_arbiter_if;
    import fb_pkg::*;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rd_rdata;

    logic              frame_start;
    logic              swap_req;
    logic              swap_ack;
    logic              front_bank;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Environment side: requesters, frame timing and the RAM itself.
    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
               frame_start, swap_req, ram_rdata,
        input  disp_rvalid, disp_rdata, wr_ready, rd_ready, rd_rvalid, rd_rdata,
               swap_ack, front_bank, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
               frame_start, swap_req, ram_rdata,
        output disp_rvalid, disp_rdata, wr_ready, rd_ready, rd_rvalid, rd_rdata,
               swap_ack, front_bank, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap sequencer: defers a swap request to the next end-of-frame pulse.
//   state     | meaning
//   SWAP_RUN  | idle, core may access the back bank
//   SWAP_PEND | swap requested, back bank frozen until frame_start
//   SWAP_DO   | one cycle: flip front_bank, pulse swap_ack
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic swap_req,
    input  logic frame_start,
    output logic swap_ack,
    output logic front_bank,
    output logic swap_pending
);

    swap_state_t state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= SWAP_RUN;
            swap_ack   <= 1'b0;
            front_bank <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                SWAP_RUN: begin
                    if (swap_req) begin
                        state <= frame_start ? SWAP_DO : SWAP_PEND;
                    end
                end
                SWAP_PEND: begin
                    if (frame_start) begin
                        state <= SWAP_DO;
                    end
                end
                SWAP_DO: begin
                    front_bank <= ~front_bank;
                    swap_ack   <= 1'b1;
                    state      <= SWAP_RUN;
                end
                default: state <= SWAP_RUN;
            endcase
        end
    end

    assign swap_pending = (state != SWAP_RUN);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display has fixed priority, core write/read alternate,
// one registered RAM access per cycle with a two-cycle read return.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    fb_arbiter_if.slave  bus
);

    grant_t grant;
    logic   last_rd;
    logic   swap_pending;
    logic   tag_disp;
    logic   tag_rd;

    fb_swap_ctrl u_swap_ctrl (
        .clock        (clock),
        .reset        (reset),
        .swap_req     (bus.swap_req),
        .frame_start  (bus.frame_start),
        .swap_ack     (bus.swap_ack),
        .front_bank   (bus.front_bank),
        .swap_pending (swap_pending)
    );

    // Reset gates the grant so the combinational readies are also 0 while held in reset.
    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            grant = GNT_NONE;
        end else if (bus.disp_req) begin
            grant = GNT_DISP;
        end else if (!swap_pending) begin
            if (bus.wr_valid && bus.rd_valid) begin
                grant = last_rd ? GNT_WR : GNT_RD;
            end else if (bus.wr_valid) begin
                grant = GNT_WR;
            end else if (bus.rd_valid) begin
                grant = GNT_RD;
            end
        end
    end

    assign bus.wr_ready = (grant == GNT_WR);
    assign bus.rd_ready = (grant == GNT_RD);

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.ram_en      <= 1'b0;
            bus.ram_we      <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wdata   <= '0;
            last_rd         <= 1'b1;
            tag_disp        <= 1'b0;
            tag_rd          <= 1'b0;
            bus.disp_rvalid <= 1'b0;
            bus.disp_rdata  <= '0;
            bus.rd_rvalid   <= 1'b0;
            bus.rd_rdata    <= '0;
        end else begin
            bus.ram_en <= (grant != GNT_NONE);
            bus.ram_we <= (grant == GNT_WR);
            case (grant)
                GNT_DISP: bus.ram_addr <= bank_addr(bus.front_bank, bus.disp_addr);
                GNT_WR: begin
                    bus.ram_addr  <= bank_addr(~bus.front_bank, bus.wr_addr);
                    bus.ram_wdata <= bus.wr_data;
                    last_rd       <= 1'b0;
                end
                GNT_RD: begin
                    bus.ram_addr <= bank_addr(~bus.front_bank, bus.rd_addr);
                    last_rd      <= 1'b1;
                end
                default: ;
            endcase

            // Tag pipe: first stage rides with the RAM access, second stage is the rvalid itself.
            tag_disp        <= (grant == GNT_DISP);
            tag_rd          <= (grant == GNT_RD);
            bus.disp_rvalid <= tag_disp;
            bus.rd_rvalid   <= tag_rd;
            if (tag_disp) begin
                bus.disp_rdata <= bus.ram_rdata;
            end
            if (tag_rd) begin
                bus.rd_rdata <= bus.ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized scoreboard bench for fb_arbiter against a behavioural bank/priority model.
module tb_fb_arbiter;
    import fb_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fb_arbiter_if bus ();

    fb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam int RAM_WORDS = 1 << (ADDR_W + 1);

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return 8'((i * 167) ^ (i >> 5) ^ 8'h3C);
    endfunction

    // Framebuffer RAM: registered address from the arbiter, data visible in the following cycle.
    logic [DATA_W-1:0] ram_mem [RAM_WORDS];
    bit preloaded = 1'b0;
    assign bus.ram_rdata = ram_mem[bus.ram_addr];
    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= init_val(i);
            preloaded <= 1'b1;
        end else if (bus.ram_en && bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_mem [2][1 << ADDR_W];
    logic [DATA_W-1:0] disp_q [$];
    logic [DATA_W-1:0] rd_q [$];

    bit m_front, m_wait, m_fire, m_ack, m_last_rd;
    bit prev_en, prev_we;
    logic [ADDR_W:0]   prev_addr;
    logic [DATA_W-1:0] prev_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_front = 0; m_wait = 0; m_fire = 0; m_ack = 0; m_last_rd = 1;
        prev_en = 0; prev_we = 0;
    endtask

    task automatic set_inputs(input bit d, input logic [ADDR_W-1:0] da, input bit wv,
                              input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                              input bit rv, input logic [ADDR_W-1:0] ra, input bit fs, input bit sr);
        bus.disp_req = d;  bus.disp_addr = da;
        bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
        bus.rd_valid = rv; bus.rd_addr = ra;
        bus.frame_start = fs; bus.swap_req = sr;
    endtask

    // Compare this cycle's combinational/registered outputs, then account for the coming edge.
    task automatic model_cycle();
        bit pend, ew, er;
        pend = m_wait | m_fire;
        ew = !bus.disp_req && !pend && bus.wr_valid && (!bus.rd_valid || m_last_rd);
        er = !bus.disp_req && !pend && bus.rd_valid && (!bus.wr_valid || !m_last_rd);
        chk("wr_ready", bus.wr_ready, ew);
        chk("rd_ready", bus.rd_ready, er);
        chk("swap_ack", bus.swap_ack, m_ack);
        chk("front_bank", bus.front_bank, m_front);
        chk("ram_en", bus.ram_en, prev_en);
        if (prev_en) begin
            chk("ram_we", bus.ram_we, prev_we);
            chk("ram_addr", bus.ram_addr, prev_addr);
        end
        if (prev_we) chk("ram_wdata", bus.ram_wdata, prev_wdata);

        prev_en = bus.disp_req | ew | er;
        prev_we = ew;
        if (bus.disp_req) begin
            disp_q.push_back(model_mem[m_front][bus.disp_addr]);
            prev_addr = {m_front, bus.disp_addr};
        end else if (ew) begin
            model_mem[~m_front][bus.wr_addr] = bus.wr_data;
            prev_addr  = {~m_front, bus.wr_addr};
            prev_wdata = bus.wr_data;
            m_last_rd  = 0;
        end else if (er) begin
            rd_q.push_back(model_mem[~m_front][bus.rd_addr]);
            prev_addr = {~m_front, bus.rd_addr};
            m_last_rd = 1;
        end

        m_ack = m_fire;
        if (m_fire) begin
            m_front = ~m_front;
            m_fire  = 0;
        end else if (m_wait) begin
            if (bus.frame_start) begin m_fire = 1; m_wait = 0; end
        end else if (bus.swap_req) begin
            if (bus.frame_start) m_fire = 1;
            else m_wait = 1;
        end
    endtask

    task automatic step(input bit d, input logic [ADDR_W-1:0] da, input bit wv,
                        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input bit rv, input logic [ADDR_W-1:0] ra, input bit fs, input bit sr);
        @(posedge clock);
        #1;
        set_inputs(d, da, wv, wa, wd, rv, ra, fs, sr);
        #3;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset = 1'b0;
        disp_q.delete();
        rd_q.delete();
        set_inputs(1, 12'h0AA, 1, 12'h0BB, 8'h77, 1, 12'h0CC, 1, 1);
        repeat (n) @(posedge clock);
        #3;
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_disp_rvalid", bus.disp_rvalid, 0);
        chk("rst_rd_rvalid", bus.rd_rvalid, 0);
        chk("rst_swap_ack", bus.swap_ack, 0);
        chk("rst_front_bank", bus.front_bank, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
    endtask

    always @(negedge clock) begin
        if (bus.disp_rvalid) begin
            if (disp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL disp_rvalid: got unexpected rvalid, required none at %0t", $time);
            end else begin
                chk("disp_rdata", bus.disp_rdata, disp_q.pop_front());
            end
        end
        if (bus.rd_rvalid) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_rvalid: got unexpected rvalid, required none at %0t", $time);
            end else begin
                chk("rd_rdata", bus.rd_rdata, rd_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) model_mem[i >> ADDR_W][i % (1 << ADDR_W)] = init_val(i);
        model_reset();
        reset = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(3);

        // Display owns the port; a held core write must never be accepted.
        for (int i = 0; i < 3; i++) step(1, 12'h123, 1, 12'h055, 8'h11, 0, 0, 0, 0);
        idle(3);

        // Both core ports held: write first after reset, then alternate; read hits the written word.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 12'h010, 8'h5A, 1, 12'h010, 0, 0);
        idle(3);

        // Write back bank, request swap, back bank frozen until frame_start, then display sees it.
        step(0, 0, 1, 12'h040, 8'hAB, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 12'h040, 8'hEE, 1, 12'h040, 0, 0);
        step(0, 0, 1, 12'h040, 8'hEE, 0, 0, 1, 0);
        step(0, 0, 1, 12'h040, 8'hEE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("front_after_swap", bus.front_bank, 1);
        step(1, 12'h040, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Swap request coincident with frame_start, with a second request ignored during the swap.
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 1, 12'h041, 8'h33, 0, 0, 0, 1);
        step(0, 0, 1, 12'h041, 8'h33, 0, 0, 0, 0);
        idle(4);

        for (int n = 0; n < 1500; n++) begin
            bit d, wv, rv, fs, sr;
            logic [ADDR_W-1:0] da, wa, ra;
            d  = ($urandom_range(0, 99) < 45);
            wv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 60);
            fs = ($urandom_range(0, 19) == 0);
            sr = ($urandom_range(0, 29) == 0);
            da = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
            wa = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
            ra = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
            step(d, da, wv, wa, 8'($urandom), rv, ra, fs, sr);
        end

        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        if (!m_front) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 1);
            idle(3);
        end

        // Reset one cycle after a read handshake: the read must never return.
        step(0, 0, 0, 0, 0, 1, 12'h321, 0, 0);
        do_reset(2);
        idle(5);

        chk("disp_q_empty", disp_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
